mux_sel_arbiter: RTL and testbench

- Registered round-robin arbiter that shares one 2:1 data mux between two requesters.
- Owns the mux select as a clocked, glitch-free register, so `sel` is never left to combinational sensitivity.
- Registers the selected data and flags it valid.
- Sits in front of the 2:1 mux datapath and replaces free-running select toggling with request-driven, fair sequencing.

---
 rtl/mux_sel_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_sel_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the select of a shared 2:1 data mux.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   req0, req1      - mux requests from requester 0 / 1
//   i0, i1          - requester data (DATA_W bits)
//   gnt0, gnt1      - registered, mutually exclusive grants
//   sel             - registered mux select (0 = i0, 1 = i1)
//   y, y_valid      - registered selected data, valid when captured under a grant
// MAX_HOLD bounds how many cycles one requester keeps the grant while the other waits.
module mux_sel_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic               sel_q, sel_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic               y_valid_q, y_valid_d;

  // Next-state, hold counter, select and data capture
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not granted last wins
        if (req0 && (!req1 || last_gnt_q)) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_d = req1 ? GRANT1 : IDLE;
        end else if (req1) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = GRANT1;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_d = req0 ? GRANT0 : IDLE;
        end else if (req0) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = GRANT0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Any state change restarts the hold count; grant entry loads select and history
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == GRANT0) begin
        last_gnt_d = 1'b0;
        sel_d      = 1'b0;
      end else if (state_d == GRANT1) begin
        last_gnt_d = 1'b1;
        sel_d      = 1'b1;
      end
    end

    gnt0_d = (state_d == GRANT0);
    gnt1_d = (state_d == GRANT1);

    // Data is captured under the grant that is already registered
    if (gnt0_q || gnt1_q) begin
      y_d       = gnt1_q ? i1 : i0;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a cycle-level ownership model.
module tb_mux_sel_arbiter;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [DATA_W-1:0] i0, i1;
  logic              gnt0, gnt1, sel, y_valid;
  logic [DATA_W-1:0] y;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  mux_sel_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: owner -1 = nobody; contended counts cycles the owner kept
  // the mux while the other side was waiting.
  int                m_owner, m_last, m_contended;
  logic              m_sel, m_valid;
  logic [DATA_W-1:0] m_y;

  always @(posedge clk) begin
    int nxt, other;
    bit want [2];
    if (reset) begin
      m_owner = -1; m_last = 1; m_contended = 0;
      m_sel = 1'b0; m_valid = 1'b0; m_y = '0;
    end else begin
      if (m_owner >= 0) begin
        m_y     = (m_owner == 1) ? i1 : i0;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      want[0] = req0;
      want[1] = req1;
      nxt = m_owner;
      if (m_owner < 0) begin
        if (want[0] && want[1]) nxt = 1 - m_last;
        else if (want[0])       nxt = 0;
        else if (want[1])       nxt = 1;
      end else begin
        other = 1 - m_owner;
        if (!want[m_owner]) begin
          nxt = want[other] ? other : -1;
        end else if (want[other]) begin
          m_contended++;
          if (m_contended >= MAX_HOLD) nxt = other;
        end
      end
      if (nxt != m_owner) begin
        m_contended = 0;
        if (nxt >= 0) begin
          m_last = nxt;
          m_sel  = (nxt == 1);
        end
      end
      m_owner = nxt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt0", 32'(gnt0), 32'(m_owner == 0));
      chk("model_gnt1", 32'(gnt1), 32'(m_owner == 1));
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_y_valid", 32'(y_valid), 32'(m_valid));
      chk("model_y", 32'(y), 32'(m_y));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0]       rot_g0;
    logic [DATA_W-1:0] vals [4];
    vals[0] = 4'h0; vals[1] = 4'h1; vals[2] = 4'h0; vals[3] = 4'h1;
    rot_g0 = 12'b1111_0000_1111;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; i0 = '0; i1 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Idle: nothing granted
    repeat (5) tick();
    chk("idle_gnt0", 32'(gnt0), 32'd0);
    chk("idle_gnt1", 32'(gnt1), 32'd0);
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_valid", 32'(y_valid), 32'd0);

    // Uncontended requester 0 streaming
    req0 = 1'b1;
    tick();
    chk("stream_gnt0", 32'(gnt0), 32'd1);
    chk("stream_valid_first", 32'(y_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      i0 = vals[k];
      tick();
      chk("stream_y", 32'(y), 32'(vals[k]));
      chk("stream_valid", 32'(y_valid), 32'd1);
    end

    // Both requesting from reset: forced rotation every MAX_HOLD cycles
    reset = 1'b1;
    tick();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; i0 = 4'h3; i1 = 4'hC;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("rot_gnt0", 32'(gnt0), 32'(rot_g0[11-k]));
      chk("rot_sel", 32'(sel), 32'(!rot_g0[11-k]));
    end

    // Drop req0 while in GRANT0 with req1 waiting: direct handover
    req0 = 1'b0;
    tick();
    chk("handover_gnt1", 32'(gnt1), 32'd1);
    chk("handover_gnt0", 32'(gnt0), 32'd0);
    chk("handover_sel", 32'(sel), 32'd1);
    tick();
    chk("handover_y", 32'(y), 32'hC);

    // Drop both in GRANT1: IDLE, sel holds, y holds, valid falls a cycle later
    req1 = 1'b0;
    tick();
    chk("release_gnt1", 32'(gnt1), 32'd0);
    chk("release_sel", 32'(sel), 32'd1);
    tick();
    chk("release_valid", 32'(y_valid), 32'd0);
    chk("release_y", 32'(y), 32'hC);
    chk("release_sel2", 32'(sel), 32'd1);

    // Reset mid-grant with hold count at 2
    req1 = 1'b1;
    tick();
    req0 = 1'b1;
    tick();
    tick();
    chk("pre_rst_gnt1", 32'(gnt1), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_valid", 32'(y_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_tie_gnt0", 32'(gnt0), 32'd1);

    // Requester 1 alone, then a tie from IDLE after a GRANT1
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    req1 = 1'b1; i1 = 4'h9;
    tick();
    chk("solo1_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    tick();
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("tie_after_g1_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
